// File: rtl/evict_writeback_buffer_pkg.sv
// rtl/evict_writeback_buffer_pkg.sv - shared cache geometry constants and victim entry layout
package evict_writeback_buffer_pkg;

  // Geometry shared with dual_port_blockram and the cache controller
  localparam int SINGLE_ELEMENT_SIZE_IN_BITS = 64;
  localparam int SET_PTR_WIDTH_IN_BITS       = 6;
  localparam int FIFO_DEPTH                  = 4;
  localparam int FIFO_PTR_WIDTH_IN_BITS      = 2;

  // A queued victim: set address in the upper bits, evicted element below
  typedef struct packed {
    logic [SET_PTR_WIDTH_IN_BITS-1:0]       set_addr;
    logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] element;
  } victim_t;

  localparam int VICTIM_WIDTH = SET_PTR_WIDTH_IN_BITS + SINGLE_ELEMENT_SIZE_IN_BITS;

endpackage

// File: rtl/evict_writeback_buffer_victim_fifo.sv
// rtl/evict_writeback_buffer_victim_fifo.sv - first-word fall-through circular FIFO with count and sticky overflow
module evict_writeback_buffer_victim_fifo
  import evict_writeback_buffer_pkg::*;
#(
  parameter int WIDTH = VICTIM_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int PTR_W = FIFO_PTR_WIDTH_IN_BITS
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             push_in,
  input  logic [WIDTH-1:0] push_data_in,
  input  logic             pop_in,
  output logic             head_valid_out,
  output logic [WIDTH-1:0] head_data_out,
  output logic             full_out,
  output logic [PTR_W:0]   count_out,
  output logic             overflow_out
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             pop_ok;
  logic             push_ok;

  // Next-state: a pop frees its slot in the same cycle, so push at full is legal with a pop
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pop_ok     = pop_in && (count_q != '0);
    push_ok    = push_in && ((count_q != DEPTH_C) || pop_ok);
    overflow_d = overflow_q | (push_in & ~push_ok);
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data_in;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, pop_ok};
  end

  // State registers; reset discards every queued entry
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Head view is forced to zero when empty so stale slots never leak out
  always_comb begin
    head_valid_out = (count_q != '0);
    head_data_out  = head_valid_out ? mem_q[rd_ptr_q] : '0;
    full_out       = (count_q == DEPTH_C);
    count_out      = count_q;
    overflow_out   = overflow_q;
  end

endmodule

// File: rtl/evict_writeback_buffer.sv
// rtl/evict_writeback_buffer.sv - captures dirty blockram victims and drains them to the next level
module evict_writeback_buffer #(
  parameter int SINGLE_ELEMENT_SIZE_IN_BITS = evict_writeback_buffer_pkg::SINGLE_ELEMENT_SIZE_IN_BITS,
  parameter int SET_PTR_WIDTH_IN_BITS       = evict_writeback_buffer_pkg::SET_PTR_WIDTH_IN_BITS,
  parameter int FIFO_DEPTH                  = evict_writeback_buffer_pkg::FIFO_DEPTH,
  parameter int FIFO_PTR_WIDTH_IN_BITS      = evict_writeback_buffer_pkg::FIFO_PTR_WIDTH_IN_BITS
) (
  input  logic                                   clk_in,
  input  logic                                   reset_in,
  input  logic                                   write_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       write_set_addr_in,
  input  logic                                   write_victim_dirty_in,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] evict_element_in,
  output logic                                   stall_out,
  output logic                                   wb_valid_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]       wb_set_addr_out,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] wb_element_out,
  input  logic                                   wb_ready_in,
  output logic [FIFO_PTR_WIDTH_IN_BITS:0]        count_out,
  output logic                                   overflow_error_out
);

  localparam int ENTRY_W = SET_PTR_WIDTH_IN_BITS + SINGLE_ELEMENT_SIZE_IN_BITS;
  localparam int OCC_W   = FIFO_PTR_WIDTH_IN_BITS + 2;

  logic                             pending_valid_q, pending_valid_d;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] pending_addr_q, pending_addr_d;
  logic [ENTRY_W-1:0]               push_data;
  logic [ENTRY_W-1:0]               head_data;
  logic                             head_valid;
  logic                             fifo_full;
  logic [FIFO_PTR_WIDTH_IN_BITS:0]  fifo_count;
  logic                             fifo_overflow;
  logic [OCC_W-1:0]                 occupancy;

  // Capture stage: remember which set a dirty write evicts; the data arrives a cycle later
  always_comb begin
    pending_valid_d = write_en_in & write_victim_dirty_in;
    pending_addr_d  = pending_valid_d ? write_set_addr_in : pending_addr_q;
    push_data       = {pending_addr_q, evict_element_in};
  end

  // Capture registers
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      pending_valid_q <= 1'b0;
      pending_addr_q  <= '0;
    end else begin
      pending_valid_q <= pending_valid_d;
      pending_addr_q  <= pending_addr_d;
    end
  end

  evict_writeback_buffer_victim_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .PTR_W (FIFO_PTR_WIDTH_IN_BITS)
  ) u_victim_fifo (
    .clk_in         (clk_in),
    .reset_in       (reset_in),
    .push_in        (pending_valid_q),
    .push_data_in   (push_data),
    .pop_in         (wb_ready_in),
    .head_valid_out (head_valid),
    .head_data_out  (head_data),
    .full_out       (fifo_full),
    .count_out      (fifo_count),
    .overflow_out   (fifo_overflow)
  );

  // Stall counts the in-flight capture so an accepted write always finds a free slot
  always_comb begin
    occupancy          = {1'b0, fifo_count} + {{(OCC_W-1){1'b0}}, pending_valid_q};
    stall_out          = (occupancy >= OCC_W'(FIFO_DEPTH)) | (fifo_full & pending_valid_q);
    wb_valid_out       = head_valid;
    wb_set_addr_out    = head_data[ENTRY_W-1:SINGLE_ELEMENT_SIZE_IN_BITS];
    wb_element_out     = head_data[SINGLE_ELEMENT_SIZE_IN_BITS-1:0];
    count_out          = fifo_count;
    overflow_error_out = fifo_overflow;
  end

endmodule

// File: tb/tb_evict_writeback_buffer.sv
// tb/tb_evict_writeback_buffer.sv - randomized and directed bench against a queue-based victim model
module tb_evict_writeback_buffer;

  localparam int EW    = 64;
  localparam int AW    = 6;
  localparam int DEPTH = 4;

  logic          clk_in;
  logic          reset_in;
  logic          write_en_in;
  logic [AW-1:0] write_set_addr_in;
  logic          write_victim_dirty_in;
  logic [EW-1:0] evict_element_in;
  logic          stall_out;
  logic          wb_valid_out;
  logic [AW-1:0] wb_set_addr_out;
  logic [EW-1:0] wb_element_out;
  logic          wb_ready_in;
  logic [2:0]    count_out;
  logic          overflow_error_out;

  int n_vec;
  int n_err;

  logic [AW+EW-1:0] mq[$];
  bit               m_pend;
  logic [AW-1:0]    m_paddr;
  bit               m_ovf;

  evict_writeback_buffer dut (
    .clk_in                (clk_in),
    .reset_in              (reset_in),
    .write_en_in           (write_en_in),
    .write_set_addr_in     (write_set_addr_in),
    .write_victim_dirty_in (write_victim_dirty_in),
    .evict_element_in      (evict_element_in),
    .stall_out             (stall_out),
    .wb_valid_out          (wb_valid_out),
    .wb_set_addr_out       (wb_set_addr_out),
    .wb_element_out        (wb_element_out),
    .wb_ready_in           (wb_ready_in),
    .count_out             (count_out),
    .overflow_error_out    (overflow_error_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_stall();
    return (mq.size() + int'(m_pend)) >= DEPTH;
  endfunction

  task automatic check_outputs();
    logic [AW+EW-1:0] head;
    head = (mq.size() != 0) ? mq[0] : '0;
    check_eq("wb_valid", 64'(wb_valid_out), 64'(mq.size() != 0));
    check_eq("wb_addr", 64'(wb_set_addr_out), 64'(head[AW+EW-1:EW]));
    check_eq("wb_data", wb_element_out, head[EW-1:0]);
    check_eq("count", 64'(count_out), 64'(mq.size()));
    check_eq("stall", 64'(stall_out), 64'(model_stall()));
    check_eq("overflow", 64'(overflow_error_out), 64'(m_ovf));
  endtask

  // One clock edge of the victim buffer, in terms of the queue it represents
  task automatic model_clock(input bit we, input logic [AW-1:0] addr, input bit dirty,
                             input logic [EW-1:0] evict, input bit ready);
    if (ready && mq.size() != 0) void'(mq.pop_front());
    if (m_pend) begin
      if (mq.size() < DEPTH) mq.push_back({m_paddr, evict});
      else m_ovf = 1'b1;
    end
    m_pend = we && dirty;
    if (m_pend) m_paddr = addr;
  endtask

  task automatic step(input bit we, input logic [AW-1:0] addr, input bit dirty,
                      input logic [EW-1:0] evict, input bit ready);
    write_en_in           = we;
    write_set_addr_in     = addr;
    write_victim_dirty_in = dirty;
    evict_element_in      = evict;
    wb_ready_in           = ready;
    @(negedge clk_in);
    check_outputs();
    @(posedge clk_in);
    model_clock(we, addr, dirty, evict, ready);
    #1;
  endtask

  function automatic logic [EW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Asynchronous reset asserted away from any clock edge, held with random inputs
  task automatic do_reset(input int cycles);
    reset_in = 1'b0;
    #1;
    mq.delete();
    m_pend = 1'b0;
    m_paddr = '0;
    m_ovf = 1'b0;
    check_outputs();
    for (int i = 0; i < cycles; i++) begin
      write_en_in           = 1'($urandom);
      write_set_addr_in     = AW'($urandom);
      write_victim_dirty_in = 1'($urandom);
      evict_element_in      = rnd64();
      wb_ready_in           = 1'($urandom);
      @(negedge clk_in);
      check_outputs();
      @(posedge clk_in);
      #1;
    end
    reset_in = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_pend = 1'b0;
    m_paddr = '0;
    m_ovf = 1'b0;
    reset_in = 1'b0;
    write_en_in = 1'b0;
    write_set_addr_in = '0;
    write_victim_dirty_in = 1'b0;
    evict_element_in = '0;
    wb_ready_in = 1'b0;

    do_reset(3);

    // Single dirty victim: visible two cycles after the write
    step(1'b1, AW'(5), 1'b1, rnd64(), 1'b0);
    step(1'b0, '0, 1'b0, 64'hDEAD_BEEF, 1'b0);
    check_eq("single_valid", 64'(wb_valid_out), 64'd1);
    check_eq("single_addr", 64'(wb_set_addr_out), 64'd5);
    check_eq("single_data", wb_element_out, 64'hDEAD_BEEF);
    check_eq("single_count", 64'(count_out), 64'd1);
    step(1'b0, '0, 1'b0, rnd64(), 1'b1);
    check_eq("single_popped", 64'(count_out), 64'd0);

    // Clean writes never queue anything
    for (int i = 0; i < 8; i++) step(1'b1, AW'(i), 1'b0, rnd64(), 1'($urandom));
    step(1'b0, '0, 1'b0, rnd64(), 1'b0);
    check_eq("clean_count", 64'(count_out), 64'd0);

    // Fill to depth with back-to-back dirty writes, no draining
    for (int i = 0; i < 4; i++) step(1'b1, AW'(10 + i), 1'b1, rnd64(), 1'b0);
    check_eq("fill_stall", 64'(stall_out), 64'd1);
    step(1'b0, '0, 1'b0, 64'h1313_0000_0000_0013, 1'b0);
    check_eq("fill_count", 64'(count_out), 64'd4);
    check_eq("fill_head", 64'(wb_set_addr_out), 64'd10);

    // Push into a full FIFO while the head pops in the same cycle
    step(1'b1, AW'(20), 1'b1, rnd64(), 1'b0);
    step(1'b0, '0, 1'b0, 64'h2020_2020_2020_2020, 1'b1);
    check_eq("pp_count", 64'(count_out), 64'd4);
    check_eq("pp_head", 64'(wb_set_addr_out), 64'd11);
    check_eq("pp_ovf", 64'(overflow_error_out), 64'd0);

    // Ignore stall: push at full with no pop must drop and flag
    step(1'b1, AW'(30), 1'b1, rnd64(), 1'b0);
    step(1'b0, '0, 1'b0, rnd64(), 1'b0);
    check_eq("ovf_flag", 64'(overflow_error_out), 64'd1);
    check_eq("ovf_count", 64'(count_out), 64'd4);
    check_eq("ovf_head", 64'(wb_set_addr_out), 64'd11);
    step(1'b0, '0, 1'b0, rnd64(), 1'b1);
    check_eq("drain_12", 64'(wb_set_addr_out), 64'd12);
    step(1'b0, '0, 1'b0, rnd64(), 1'b1);
    check_eq("drain_13", 64'(wb_set_addr_out), 64'd13);
    check_eq("drain_13_data", wb_element_out, 64'h1313_0000_0000_0013);

    // Mid-stream reset with entries still queued
    step(1'b1, AW'(40), 1'b1, rnd64(), 1'b0);
    do_reset(2);
    check_eq("post_reset_count", 64'(count_out), 64'd0);

    // Random traffic; the writer mostly respects stall but occasionally violates it
    for (int i = 0; i < 600; i++) begin
      bit we, dirty;
      we = ($urandom_range(0, 3) != 0);
      dirty = 1'($urandom);
      if (we && dirty && model_stall() && ($urandom_range(0, 19) != 0)) dirty = 1'b0;
      step(we, AW'($urandom_range(0, 3)), dirty, rnd64(), ($urandom_range(0, 2) == 0));
      if (i == 300) do_reset(1);
    end
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0, rnd64(), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/evict_writeback_buffer.md
Name: evict_writeback_buffer

Overview:
- Sits directly downstream of dual_port_blockram and consumes its evict_element_out.
- Captures the evicted (old) element together with its set address one cycle after each qualifying write, then queues it in a small FIFO.
- Drains the queue to the next memory level over a valid/ready handshake.
- Back-pressures the writer through stall_out so that no victim is ever lost.

Parameters:
- SINGLE_ELEMENT_SIZE_IN_BITS, 64, element width; matches the blockram.
- SET_PTR_WIDTH_IN_BITS, 6, set address width; matches the blockram.
- FIFO_DEPTH, 4, number of victim entries; power of two, ≥2.
- FIFO_PTR_WIDTH_IN_BITS, 2, log2(FIFO_DEPTH).

Ports:
- clk_in  input  1  single clock.
- reset_in  input  1  asynchronous, active-low reset.
- write_en_in  input  1  same strobe that drives blockram write_en_in.
- write_set_addr_in  input  SET_PTR_WIDTH_IN_BITS  same address that drives blockram write_set_addr_in.
- write_victim_dirty_in  input  1  old entry at write_set_addr_in needs writeback; sampled with write_en_in.
- evict_element_in  input  SINGLE_ELEMENT_SIZE_IN_BITS  from blockram evict_element_out; valid the cycle after the write.
- stall_out  output  1  writer must not issue a dirty-victim write this cycle.
- wb_valid_out  output  1  head entry available.
- wb_set_addr_out  output  SET_PTR_WIDTH_IN_BITS  head entry set address.
- wb_element_out  output  SINGLE_ELEMENT_SIZE_IN_BITS  head entry data.
- wb_ready_in  input  1  consumer accepts head.
- count_out  output  FIFO_PTR_WIDTH_IN_BITS+1  occupied entries.
- overflow_error_out  output  1  sticky; a victim was dropped.

Behaviour:
- Reset (reset_in low, asynchronous):
  - Clears pointers, count, the pending-capture register and overflow_error_out.
  - Outputs during and after reset: wb_valid_out=0, wb_set_addr_out=0, wb_element_out=0, count_out=0, stall_out=0, overflow_error_out=0.
  - Reset mid-operation discards all queued and pending victims.
- Stage 1 (cycle T): if write_en_in && write_victim_dirty_in, register pending_valid=1 and pending_addr=write_set_addr_in. Otherwise pending_valid=0.
- Stage 2 (cycle T+1): if pending_valid, push {pending_addr, evict_element_in} at the tail.
- Entry latency: the entry becomes visible on wb_* at T+2, or later if older entries are ahead of it.
- Clean writes (write_victim_dirty_in=0) never push.
- FIFO organisation: circular buffer of FIFO_DEPTH entries.
  - Pointers are FIFO_PTR_WIDTH_IN_BITS bits and wrap naturally from DEPTH-1 to 0.
  - count is a separate counter, range 0..DEPTH.
- Output side:
  - First-word fall-through: wb_valid_out = (count != 0).
  - wb_set_addr_out and wb_element_out show the head entry; they are 0 when empty.
  - Pop occurs when wb_valid_out && wb_ready_in.
  - wb_* must hold stable while valid and not accepted.
- Simultaneous push and pop:
  - count is unchanged; both pointers advance.
  - Legal when full, because the pop frees the slot in the same cycle.
  - When count=0, the pushed entry is not bypassed; it appears the next cycle.
- stall_out = (count + pending_valid) ≥ FIFO_DEPTH, purely combinational from registers.
  - This guarantees that a write accepted while stall_out=0 always has a slot at push time, even with no pop.
- Overflow (protocol violation: push at count=DEPTH with no same-cycle pop):
  - Drop the entry; the FIFO contents are unchanged.
  - Set overflow_error_out=1 and hold it until reset.
- Pop when empty: ignored; wb_ready_in alone has no effect.
- No reordering: entries drain strictly in write order, including repeated addresses. Duplicates are not merged.

Decomposition:
- Shared package/`include (parameters.h): SINGLE_ELEMENT_SIZE_IN_BITS, SET_PTR_WIDTH_IN_BITS, and the default FIFO_DEPTH constant, shared with dual_port_blockram and the cache controller.
- One natural sub-module: victim_fifo.
  - Generic synchronous FWFT FIFO with count, full/empty and overflow flag.
  - The top level adds the capture stage, the stall logic and the port mapping.

Test Plan:
- Reset then idle: hold reset_in=0 for 3 cycles with random inputs. Then wb_valid_out=0, count_out=0, stall_out=0, overflow_error_out=0 throughout.
- Single dirty victim:
  - Write addr 5, dirty=1 at cycle T; evict_element_in=0xDEAD_BEEF at T+1; wb_ready_in=0.
  - At T+2: wb_valid_out=1, wb_set_addr_out=5, wb_element_out=0xDEADBEEF, count_out=1.
  - Assert wb_ready_in and confirm the entry pops; count_out returns to 0.
- Clean write filter: 8 writes to addrs 0..7 with dirty=0 and random evict data. Then wb_valid_out stays 0 and count_out stays 0.
- Fill and stall:
  - wb_ready_in=0; issue dirty writes back to back to addrs 10,11,12,13.
  - stall_out rises the cycle the 4th write is pending.
  - count_out reaches 4.
  - Output order is 10,11,12,13 with the matching data.
- Full with simultaneous push and pop: at count=4, assert wb_ready_in and issue one dirty write to addr 20. count_out stays 4, the head advances to 11, addr 20 lands last, and overflow_error_out=0.
- Overflow and mid-operation reset:
  - At count=4 with wb_ready_in=0, force a dirty write while ignoring stall_out.
  - Expect overflow_error_out=1 and contents unchanged.
  - Pulse reset_in low mid-stream; all outputs return to 0 asynchronously.
